instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 127 ++++++++++++
 tb/tb_instruction_fetch.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues word addresses to a one-cycle-latency memory and hands words to decode.
// Optional program-end bounds checking (DRAIN/DONE states, Done output) is enabled by defining FETCH_BOUNDS_EN.
module instruction_fetch #(
  parameter logic [8:0] RESET_PC  = 9'h000,
  parameter int         LAST_WORD = 34
) (
  input  logic        clock,
  input  logic        Reset,
  output logic [6:0]  ImemAdress,
  input  logic [31:0] ImemData,
  output logic [31:0] InstData,
  output logic [31:0] InstPC,
  output logic        InstValid,
  input  logic        InstReady,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectPC,
  output logic        Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
`ifdef FETCH_BOUNDS_EN
    ,
    DRAIN = 2'd2,
    DONE  = 2'd3
`endif
  } state_e;

  localparam logic [6:0] LastWordIdx = 7'(LAST_WORD);

  state_e     state_q, state_d;
  logic [8:0] pc_q, pc_d;
  logic [8:0] issued_pc_q, issued_pc_d;
  logic       issued_valid_q, issued_valid_d;

  logic [6:0] target_word;
  logic [8:0] target_pc;
  logic       inst_valid;
  logic       hold;
  logic       fetching;

  assign target_word = RedirectPC[8:2];
  assign target_pc   = {RedirectPC[8:2], 2'b00};

`ifdef FETCH_BOUNDS_EN
  assign fetching = (state_q == RUN) || (state_q == DRAIN);
  assign Done     = (state_q == DONE);
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^{RedirectPC[31:9], RedirectPC[1:0]};
`else
  assign fetching = (state_q == RUN);
  assign Done     = 1'b0;
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^{RedirectPC[31:9], RedirectPC[1:0], LastWordIdx};
`endif

  assign inst_valid = issued_valid_q && !RedirectValid && fetching;
  assign hold       = inst_valid && !InstReady;
  assign InstValid  = inst_valid;
  assign InstData   = ImemData;
  assign InstPC     = {23'd0, issued_pc_q};

  // IDLE keeps the reset address on the bus; DRAIN/DONE re-present the last issued word.
  always_comb begin
    ImemAdress = pc_q[8:2];
    if (state_q == IDLE) begin
      ImemAdress = pc_q[8:2];
    end else if (RedirectValid) begin
      ImemAdress = target_word;
    end else if (hold || (state_q != RUN)) begin
      ImemAdress = issued_pc_q[8:2];
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    issued_pc_d    = issued_pc_q;
    issued_valid_d = issued_valid_q;
    if (state_q == IDLE) begin
      state_d = RUN;
    end else if (RedirectValid) begin
      issued_pc_d    = target_pc;
      issued_valid_d = 1'b1;
      pc_d           = target_pc + 9'd4;
`ifdef FETCH_BOUNDS_EN
      if (target_word > LastWordIdx) begin
        state_d = DONE;
      end else if (target_word == LastWordIdx) begin
        state_d = DRAIN;
      end else begin
        state_d = RUN;
      end
`endif
    end else if ((state_q == RUN) && !hold) begin
      issued_pc_d    = pc_q;
      issued_valid_d = 1'b1;
      pc_d           = pc_q + 9'd4;
`ifdef FETCH_BOUNDS_EN
      if (pc_q[8:2] == LastWordIdx) begin
        state_d = DRAIN;
      end
`endif
    end
`ifdef FETCH_BOUNDS_EN
    else if ((state_q == DRAIN) && inst_valid && InstReady) begin
      state_d = DONE;
    end
`endif
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      issued_pc_q    <= 9'd0;
      issued_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      issued_pc_q    <= issued_pc_d;
      issued_valid_q <= issued_valid_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with a synchronous-read memory model.
module tb_instruction_fetch;

  logic        clock;
  logic        Reset;
  logic [6:0]  ImemAdress;
  logic [31:0] ImemData;
  logic [31:0] InstData;
  logic [31:0] InstPC;
  logic        InstValid;
  logic        InstReady;
  logic        RedirectValid;
  logic [31:0] RedirectPC;
  logic        Done;

  int checks = 0;
  int errors = 0;

  instruction_fetch dut (
    .clock        (clock),
    .Reset        (Reset),
    .ImemAdress   (ImemAdress),
    .ImemData     (ImemData),
    .InstData     (InstData),
    .InstPC       (InstPC),
    .InstValid    (InstValid),
    .InstReady    (InstReady),
    .RedirectValid(RedirectValid),
    .RedirectPC   (RedirectPC),
    .Done         (Done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] memWord(input logic [6:0] w);
    return {16'hCAFE, 1'b0, w, 1'b0, w};
  endfunction

  always @(posedge clock) ImemData <= memWord(ImemAdress);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic ready, input logic rv, input logic [31:0] rpc);
    InstReady     = ready;
    RedirectValid = rv;
    RedirectPC    = rpc;
    #1;
  endtask

  task automatic checkFetch(input string tag, input logic [31:0] pc);
    logic [6:0] w;
    w = pc[8:2];
    checkOutput({tag, " valid"}, {31'd0, InstValid}, 32'd1);
    checkOutput({tag, " pc"}, InstPC, pc);
    checkOutput({tag, " data"}, InstData, memWord(w));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    Reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'd0);
    tick();
    tick();
    checkOutput("reset valid", {31'd0, InstValid}, 32'd0);
    checkOutput("reset done", {31'd0, Done}, 32'd0);
    checkOutput("reset addr", {25'd0, ImemAdress}, 32'd0);

    // Reset release: IDLE edge, then the first word shows up after the second edge.
    Reset = 1'b1;
    tick();
    checkOutput("idle valid", {31'd0, InstValid}, 32'd0);
    tick();
    checkFetch("first", 32'd0);
    tick();
    checkFetch("seq4", 32'd4);
    tick();
    checkFetch("seq8", 32'd8);
    tick();
    checkFetch("seq12", 32'd12);

    applyStimulus(1'b1, 1'b1, 32'd8);
    checkOutput("redir8 valid", {31'd0, InstValid}, 32'd0);
    checkOutput("redir8 addr", {25'd0, ImemAdress}, 32'd2);
    tick();
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkFetch("at8", 32'd8);

    // Back-pressure for three edges while word 8 sits on the output.
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("hold addr0", {25'd0, ImemAdress}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkFetch("hold", 32'd8);
      checkOutput("hold addr", {25'd0, ImemAdress}, 32'd2);
    end
    applyStimulus(1'b1, 1'b0, 32'd0);
    tick();
    checkFetch("after hold", 32'd12);
    tick();
    checkFetch("seq16", 32'h10);

    applyStimulus(1'b1, 1'b1, 32'h40);
    checkOutput("redir40 valid", {31'd0, InstValid}, 32'd0);
    checkOutput("redir40 addr", {25'd0, ImemAdress}, 32'h10);
    tick();
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkFetch("at40", 32'h40);
    tick();
    checkFetch("at44", 32'h44);

    // Redirect beats hold; upper and low target bits are ignored.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FE23);
    checkOutput("redir+hold valid", {31'd0, InstValid}, 32'd0);
    checkOutput("redir+hold addr", {25'd0, ImemAdress}, 32'd8);
    tick();
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkFetch("at20", 32'h20);
    tick();
    checkFetch("at24", 32'h24);

    applyStimulus(1'b0, 1'b0, 32'd0);
    tick();
    checkFetch("pre-reset hold", 32'h24);
    Reset = 1'b0;
    #1;
    checkOutput("midreset valid", {31'd0, InstValid}, 32'd0);
    checkOutput("midreset pc", InstPC, 32'd0);
    checkOutput("midreset addr", {25'd0, ImemAdress}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    tick();
    Reset = 1'b1;
    tick();
    checkOutput("re-idle valid", {31'd0, InstValid}, 32'd0);
    tick();
    checkFetch("re-first", 32'd0);

`ifdef FETCH_BOUNDS_EN
    applyStimulus(1'b1, 1'b1, 32'h80);
    tick();
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkFetch("w32", 32'h80);
    tick();
    checkFetch("w33", 32'h84);
    tick();
    checkFetch("w34", 32'h88);
    checkOutput("drain addr", {25'd0, ImemAdress}, 32'd34);
    checkOutput("drain done", {31'd0, Done}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    tick();
    checkFetch("drain hold", 32'h88);
    checkOutput("drain hold addr", {25'd0, ImemAdress}, 32'd34);
    applyStimulus(1'b1, 1'b0, 32'd0);
    tick();
    checkOutput("done flag", {31'd0, Done}, 32'd1);
    checkOutput("done valid", {31'd0, InstValid}, 32'd0);
    checkOutput("done addr", {25'd0, ImemAdress}, 32'd34);
    tick();
    checkOutput("done stays", {31'd0, Done}, 32'd1);
    applyStimulus(1'b1, 1'b1, 32'd0);
    checkOutput("restart valid", {31'd0, InstValid}, 32'd0);
    checkOutput("restart addr", {25'd0, ImemAdress}, 32'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkFetch("restart", 32'd0);
    checkOutput("restart done", {31'd0, Done}, 32'd0);
    tick();
    checkFetch("restart4", 32'd4);
    applyStimulus(1'b1, 1'b1, 32'h90);
    checkOutput("oob valid", {31'd0, InstValid}, 32'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("oob done", {31'd0, Done}, 32'd1);
    checkOutput("oob valid next", {31'd0, InstValid}, 32'd0);
`else
    applyStimulus(1'b1, 1'b1, 32'h1F0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkFetch("wrap0", 32'h1F0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkFetch("wrap", (32'h1F0 + 32'(4 * i)) & 32'h1FF);
      checkOutput("wrap done", {31'd0, Done}, 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
